conv_window: RTL and testbench
==============================

CONV_WINDOW -- requirements
Module: conv_window

Interface
REQ-001 SHALL have parameter I_BIT_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter K_SIZE, default 3, window edge; only 3 supported.
REQ-003 SHALL have parameter IMG_WIDTH, default 32, pixels per line, legal range 3..1024.
REQ-004 SHALL have parameter IMG_HEIGHT, default 32, lines per frame, legal range 3..1024.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, in_pixel valid this cycle.
REQ-008 SHALL have port in_pixel, input, I_BIT_WIDTH, signed raster-order pixel.
REQ-009 SHALL have port out_valid, output, 1, window valid this cycle.
REQ-010 SHALL have port window, output, I_BIT_WIDTH*K_SIZE*K_SIZE, signed packed 3x3 window for the downstream multiply-add stage.

Function
REQ-011 SHALL accept one pixel per cycle with in_valid=1; in_valid=0 cycles are gaps that change no state; there is no backpressure.
REQ-012 SHALL track column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), advancing only on accepted pixels; col wraps to 0 and row increments; after the frame's last pixel (row=IMG_HEIGHT-1, col=IMG_WIDTH-1) both wrap to 0.
REQ-013 SHALL hold two line buffers of IMG_WIDTH entries (previous two lines) plus a 3x3 shift register; each accepted pixel shifts the window left by one column, loading the new right column from (line-2, line-1, current pixel).
REQ-014 SHALL pack element index i = 3*r + c at bits [I_BIT_WIDTH*(i+1)-1 : I_BIT_WIDTH*i]; r=0 is the oldest (top) row, c=0 the oldest (left) column, so index 8 is the newest pixel.
REQ-015 SHALL assert out_valid for exactly one cycle, the cycle after accepting a pixel with row>=2 and col>=2 (latency 1); otherwise out_valid=0.
REQ-016 SHALL emit exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame; no padding; windows never span a line or frame boundary.
REQ-017 SHALL hold window stable when out_valid=0; its value is don't-care to consumers then.
REQ-018 SHALL pass pixel values bit-exact, no arithmetic or sign change.
REQ-019 SHALL start each new frame with line buffer contents treated as stale; no window of the new frame contains previous-frame pixels (guaranteed by REQ-015 row gating).

Reset
REQ-020 SHALL, when rst=1 at a clock edge, clear col, row, out_valid to 0 and window to 0, regardless of in_valid.
REQ-021 SHALL ignore in_pixel in a reset cycle; the first pixel after rst deasserts is row 0, col 0.
REQ-022 SHALL, on reset mid-frame, discard the partial frame; line buffer RAM need not be cleared.

Configuration
REQ-023 SHALL, when CONV_WINDOW_LAST_EN is defined, add output win_last (1 bit, reset 0), high with out_valid for the final window of a frame (newest pixel row=IMG_HEIGHT-1, col=IMG_WIDTH-1), else 0.
REQ-024 SHALL, when CONV_WINDOW_LAST_EN is undefined, omit win_last port and logic; all other behaviour identical.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, I_BIT_WIDTH=8)
REQ-025 SHALL check: pixels 0..15 back-to-back -> first out_valid the cycle after pixel 10; window bytes index0..8 = 0,1,2,4,5,6,8,9,10.
REQ-026 SHALL check: same frame -> exactly 4 windows, after pixels 10,11,14,15; last = 5,6,7,9,10,11,13,14,15; win_last=1 only on it when macro defined.
REQ-027 SHALL check: same frame with in_valid=0 gap after every pixel -> identical window sequence, each out_valid one cycle after its accepting pixel.
REQ-028 SHALL check: two frames back-to-back, second pixels 100..115 -> second frame first window 100,101,102,104,105,106,108,109,110, no frame-1 data.
REQ-029 SHALL check: rst=1 after pixel 9 then pixels 0..15 -> out_valid=0, window=0 during reset; then REQ-025 result.
REQ-030 SHALL check: signed pixels -128,127 -> reproduced bit-exact in window (8'h80, 8'h7F).

Source files
------------

// File: rtl/conv_window.sv
// conv_window: raster-order 3x3 sliding-window generator.
// Two line buffers hold the previous two image lines; a 3x3 shift register
// assembles each window, and a separate output register presents it to the
// downstream multiply-add stage with a one-cycle latency.
// Optional feature: define CONV_WINDOW_LAST_EN to add the win_last output,
// which flags the final window of each frame.
// Pixels are signed two's complement and pass through bit-exact.

module conv_window #(
    parameter int I_BIT_WIDTH = 8,
    parameter int K_SIZE      = 3,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic [I_BIT_WIDTH-1:0]                in_pixel,
    output logic                                  out_valid,
    output logic [I_BIT_WIDTH*K_SIZE*K_SIZE-1:0]  window
`ifdef CONV_WINDOW_LAST_EN
    ,
    output logic                                  win_last
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int NE = K_SIZE * K_SIZE;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(K_SIZE - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(K_SIZE - 1);

    // Position of the pixel currently presented on in_pixel.
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // lb1 holds line-1, lb2 holds line-2; both indexed by column.
    logic [I_BIT_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [I_BIT_WIDTH-1:0] lb2 [IMG_WIDTH];
    logic [I_BIT_WIDTH-1:0] lb1_rd;
    logic [I_BIT_WIDTH-1:0] lb2_rd;

    // Window shift register, element i = K_SIZE*r + c (r=0 top, c=0 left).
    logic [I_BIT_WIDTH-1:0] sr      [NE];
    logic [I_BIT_WIDTH-1:0] sr_next [NE];

    logic [I_BIT_WIDTH*NE-1:0] window_next;

    logic accept;
    logic emit;
    logic col_wrap;
    logic row_wrap;

    assign accept   = in_valid & ~rst;
    assign col_wrap = (col == COL_LAST);
    assign row_wrap = (row == ROW_LAST);

    // A window is complete once at least three rows and three columns of
    // the current frame have been seen; this gating also keeps stale line
    // buffer data from a previous or aborted frame out of every window.
    assign emit = accept && (row >= ROW_MIN) && (col >= COL_MIN);

    assign lb1_rd = lb1[col];
    assign lb2_rd = lb2[col];

    // Raster position counters; advance only on accepted pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (col_wrap) begin
                col <= '0;
                if (row_wrap) begin
                    row <= '0;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers: push the column's line-1 value down to line-2 and store
    // the new pixel as line-1. Contents are never cleared; row gating hides them.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[col] <= lb1[col];
            lb1[col] <= in_pixel;
        end
    end

    // Next shift-register state: shift left one column, load the new right
    // column from (line-2, line-1, current pixel).
    always_comb begin
        sr_next = sr;
        if (accept) begin
            for (int unsigned r = 0; r < K_SIZE; r++) begin
                for (int unsigned c = 0; c + 1 < K_SIZE; c++) begin
                    sr_next[K_SIZE*r + c] = sr[K_SIZE*r + c + 1];
                end
            end
            sr_next[K_SIZE - 1]      = lb2_rd;
            sr_next[2*K_SIZE - 1]    = lb1_rd;
            sr_next[K_SIZE*K_SIZE-1] = in_pixel;
        end
    end

    // Pack the next shift-register state into the flat output layout.
    always_comb begin
        window_next = '0;
        for (int unsigned i = 0; i < NE; i++) begin
            window_next[I_BIT_WIDTH*i +: I_BIT_WIDTH] = sr_next[i];
        end
    end

    // Shift register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '{default: '0};
        end else begin
            sr <= sr_next;
        end
    end

    // Output register: loads only when a window is emitted, so window stays
    // stable while out_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            window    <= '0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                window <= window_next;
            end
        end
    end

`ifdef CONV_WINDOW_LAST_EN
    // Flag the window whose newest pixel is the frame's last pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_last <= 1'b0;
        end else begin
            win_last <= emit && col_wrap && row_wrap;
        end
    end
`endif

endmodule

// File: tb/tb_conv_window.sv
// tb_conv_window: directed self-checking bench for conv_window on a 4x4
// image with 8-bit pixels. Expected windows come from a hand-written table
// of pixel indices per window.

module tb_conv_window;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_pixel = '0;
    logic           out_valid;
    logic [W*9-1:0] window;
`ifdef CONV_WINDOW_LAST_EN
    logic           win_last;
`endif

    int passed = 0;
    int total  = 0;

    // Pixel values of the frame currently being sent.
    logic [W-1:0] pix [16];

    // Pixel indices of each window element (index 0..8) for the 4 windows.
    int off [4][9] = '{
        '{0, 1, 2, 4, 5, 6, 8,  9,  10},
        '{1, 2, 3, 5, 6, 7, 9,  10, 11},
        '{4, 5, 6, 8, 9, 10, 12, 13, 14},
        '{5, 6, 7, 9, 10, 11, 13, 14, 15}
    };

    // out_valid expected after pixels 10, 11, 14, 15.
    logic [15:0] vmask = 16'hCC00;

    conv_window #(
        .I_BIT_WIDTH (8),
        .K_SIZE      (3),
        .IMG_WIDTH   (4),
        .IMG_HEIGHT  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .window    (window)
`ifdef CONV_WINDOW_LAST_EN
        ,
        .win_last  (win_last)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [71:0] exp_win(input int wi);
        logic [71:0] e;
        e = '0;
        for (int i = 0; i < 9; i++) begin
            e[8*i +: 8] = pix[off[wi][i]];
        end
        return e;
    endfunction

    task automatic set_ramp(input int base);
        for (int k = 0; k < 16; k++) begin
            pix[k] = 8'(base + k);
        end
    endtask

    // Send one full frame from pix[], optionally with an idle cycle after
    // every pixel, checking out_valid/window/win_last after each edge.
    task automatic run_frame(input string name, input bit gaps);
        int wi;
        wi = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_pixel = pix[k];
            @(posedge clk);
            #1;
            check($sformatf("%s valid px%0d", name, k), {71'b0, out_valid}, {71'b0, vmask[k]});
            if (vmask[k]) begin
                check($sformatf("%s window%0d", name, wi), window, exp_win(wi));
                wi++;
            end
`ifdef CONV_WINDOW_LAST_EN
            check($sformatf("%s win_last px%0d", name, k), {71'b0, win_last}, {71'b0, (k == 15)});
`endif
            if (gaps) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_pixel = 8'hEE;
                @(posedge clk);
                #1;
                check($sformatf("%s gap valid px%0d", name, k), {71'b0, out_valid}, 72'd0);
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_pixel = '0;
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("reset valid", {71'b0, out_valid}, 72'd0);
            check("reset window", window, 72'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Basic frame, then a second frame back-to-back.
        set_ramp(0);
        run_frame("f0", 1'b0);
        set_ramp(100);
        run_frame("f100", 1'b0);
        go_idle();

        // Same frame with an idle cycle after every pixel.
        set_ramp(0);
        run_frame("gap", 1'b1);
        go_idle();

        // Partial frame (pixels 0..9), then reset with a live pixel present.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_pixel = 8'(k);
            @(posedge clk);
            #1;
            check($sformatf("partial valid px%0d", k), {71'b0, out_valid}, 72'd0);
        end
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_pixel = 8'h37;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("midreset valid", {71'b0, out_valid}, 72'd0);
            check("midreset window", window, 72'd0);
`ifdef CONV_WINDOW_LAST_EN
            check("midreset win_last", {71'b0, win_last}, 72'd0);
`endif
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        set_ramp(0);
        run_frame("postrst", 1'b0);
        go_idle();

        // Extreme signed values must pass through unchanged.
        set_ramp(0);
        pix[0]  = 8'h80;
        pix[10] = 8'h7F;
        run_frame("signed", 1'b0);
        go_idle();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
